// File: rtl/backend_pkg.sv
// Shared types for the serial configuration port: frame FSM states, status codes
// and the frame-length helper.
package backend_pkg;

    // S_CMD is folded into the IDLE edge that samples RW, so the FSM never rests in it.
    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DATA,
        S_PAR,
        S_HOLD
    } state_e;

    typedef enum logic [1:0] {
        ST_NONE = 2'b00,
        ST_OK   = 2'b01,
        ST_PAR  = 2'b10,
        ST_REJ  = 2'b11
    } status_e;

    function automatic int frame_len(input int addr_w, input int data_w);
        return 2 + addr_w + data_w;
    endfunction

    localparam int FRAME_LEN = frame_len(3, 8);

endpackage

// File: rtl/cfg_regfile.sv
// NREG x DATA_W configuration register file with a single write port, a reset image
// and the write-protect lock held in bit 0 of the last register.
module cfg_regfile
    import backend_pkg::*;
#(
    parameter int                       ADDR_W    = 3,
    parameter int                       DATA_W    = 8,
    parameter int                       NREG      = 8,
    parameter logic [NREG*DATA_W-1:0]   RESET_VAL = '0,
    parameter bit                       WP_EN     = 1'b1
) (
    input  logic                    i_sclk,
    input  logic                    i_resetbAll,
    input  logic                    i_we,
    input  logic [ADDR_W-1:0]       i_addr,
    input  logic [DATA_W-1:0]       i_wdata,
    output logic                    o_locked,
    output logic [NREG*DATA_W-1:0]  o_cfg
);

    logic [NREG*DATA_W-1:0] cfg_q, cfg_d;
    logic                   lock_bit;

    always_comb begin
        cfg_d = cfg_q;
        if (i_we) begin
            for (int k = 0; k < NREG; k++) begin
                if (i_addr == ADDR_W'(k)) cfg_d[k*DATA_W +: DATA_W] = i_wdata;
            end
        end
    end

    // The lock register itself stays writable so software can always release the lock.
    assign lock_bit = WP_EN && cfg_q[(NREG-1)*DATA_W];
    assign o_locked = lock_bit && (i_addr != ADDR_W'(NREG-1));

    // NOTE: this bank is reset on purpose: the analog backend must see a defined
    // configuration straight out of reset, so the storage is flops, not a RAM.
    always_ff @(posedge i_sclk or negedge i_resetbAll) begin
        if (!i_resetbAll) cfg_q <= RESET_VAL;
        else              cfg_q <= cfg_d;
    end

    assign o_cfg = cfg_q;

endmodule

// File: rtl/serial_cfg_regbank.sv
// Serial configuration port: frame FSM, address/data shifters, parity check and
// read-back serialiser in front of cfg_regfile; commits are flagged by a toggle.
module serial_cfg_regbank
    import backend_pkg::*;
#(
    parameter int                       ADDR_W    = 3,
    parameter int                       DATA_W    = 8,
    parameter int                       NREG      = 8,
    parameter logic [NREG*DATA_W-1:0]   RESET_VAL = '0,
    parameter bit                       WP_EN     = 1'b1
) (
    input  logic                    i_sclk,
    input  logic                    i_resetbAll,
    input  logic                    i_sen,
    input  logic                    i_sdin,
    output logic                    o_sdout,
    output logic [NREG*DATA_W-1:0]  o_cfg,
    output logic                    o_wr_toggle,
    output logic [ADDR_W-1:0]       o_wr_addr,
    output logic [1:0]              o_status,
    output logic [3:0]              o_err_cnt,
    output logic                    o_busy
);

    localparam int CNT_W = $clog2(frame_len(ADDR_W, DATA_W));

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               rw_q, rw_d;
    logic               par_q, par_d;
    logic [ADDR_W-1:0]  addr_sh_q, addr_sh_d;
    logic [DATA_W-1:0]  data_sh_q, data_sh_d;
    logic [DATA_W-1:0]  rd_sh_q, rd_sh_d;
    logic               rd_par_q, rd_par_d;
    logic               sdout_q, sdout_d;
    logic               wr_toggle_q, wr_toggle_d;
    logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
    status_e            status_q, status_d;
    logic [3:0]         err_cnt_q, err_cnt_d;
    logic               busy_q, busy_d;

    logic [ADDR_W-1:0]      addr_nxt;
    logic [DATA_W-1:0]      data_nxt;
    logic [DATA_W-1:0]      rd_val;
    logic                   frame_par;
    logic                   addr_ok;
    logic                   we;
    logic                   err;
    logic                   wr_locked;
    logic [NREG*DATA_W-1:0] cfg;

    cfg_regfile #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .NREG      (NREG),
        .RESET_VAL (RESET_VAL),
        .WP_EN     (WP_EN)
    ) u_regfile (
        .i_sclk      (i_sclk),
        .i_resetbAll (i_resetbAll),
        .i_we        (we),
        .i_addr      (addr_sh_q),
        .i_wdata     (data_sh_q),
        .o_locked    (wr_locked),
        .o_cfg       (cfg)
    );

    // Read-back source is selected with the address including the bit arriving now.
    always_comb begin
        rd_val = '0;
        for (int k = 0; k < NREG; k++) begin
            if (addr_nxt == ADDR_W'(k)) rd_val = cfg[k*DATA_W +: DATA_W];
        end
    end

    // NOTE: combinational next-state logic uses blocking '=' and assigns a default
    // to every output first, so no path through the case can infer a latch.
    always_comb begin
        addr_nxt  = ADDR_W'({addr_sh_q, i_sdin});
        data_nxt  = DATA_W'({data_sh_q, i_sdin});
        frame_par = par_q ^ i_sdin;
        addr_ok   = int'(addr_sh_q) < NREG;

        state_d     = state_q;
        cnt_d       = cnt_q;
        rw_d        = rw_q;
        par_d       = par_q;
        addr_sh_d   = addr_sh_q;
        data_sh_d   = data_sh_q;
        rd_sh_d     = rd_sh_q;
        rd_par_d    = rd_par_q;
        sdout_d     = 1'b0;
        wr_toggle_d = wr_toggle_q;
        wr_addr_d   = wr_addr_q;
        status_d    = status_q;
        err_cnt_d   = err_cnt_q;
        we          = 1'b0;
        err         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_sen) begin
                    rw_d    = i_sdin;
                    par_d   = i_sdin;
                    cnt_d   = '0;
                    state_d = S_ADDR;
                end
            end
            S_ADDR, S_DATA, S_PAR: begin
                if (!i_sen) begin
                    status_d = ST_REJ;
                    err      = 1'b1;
                    state_d  = S_IDLE;
                end else if (state_q == S_ADDR) begin
                    addr_sh_d = addr_nxt;
                    par_d     = frame_par;
                    cnt_d     = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(ADDR_W-1)) begin
                        cnt_d   = '0;
                        state_d = S_DATA;
                        if (!rw_q) begin
                            rd_sh_d  = rd_val;
                            rd_par_d = ^rd_val;
                            sdout_d  = rd_val[DATA_W-1];
                        end
                    end
                end else if (state_q == S_DATA) begin
                    data_sh_d = data_nxt;
                    par_d     = frame_par;
                    cnt_d     = cnt_q + CNT_W'(1);
                    if (!rw_q) begin
                        rd_sh_d = rd_sh_q << 1;
                        sdout_d = rd_sh_d[DATA_W-1];
                    end
                    if (cnt_q == CNT_W'(DATA_W-1)) state_d = S_PAR;
                end else begin
                    state_d = S_HOLD;
                    if (!rw_q) sdout_d = rd_par_q;
                    if (frame_par) begin
                        status_d = ST_PAR;
                        err      = 1'b1;
                    end else if (!addr_ok || (rw_q && wr_locked)) begin
                        status_d = ST_REJ;
                        err      = 1'b1;
                    end else begin
                        status_d = ST_OK;
                        if (rw_q) begin
                            we          = 1'b1;
                            wr_toggle_d = ~wr_toggle_q;
                            wr_addr_d   = addr_sh_q;
                        end
                    end
                end
            end
            S_HOLD: begin
                if (!i_sen) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (err && (err_cnt_q != 4'hF)) err_cnt_d = err_cnt_q + 4'd1;
        busy_d = (state_d == S_ADDR) || (state_d == S_DATA) || (state_d == S_PAR);
    end

    always_ff @(posedge i_sclk or negedge i_resetbAll) begin
        if (!i_resetbAll) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            rw_q        <= 1'b0;
            par_q       <= 1'b0;
            addr_sh_q   <= '0;
            data_sh_q   <= '0;
            rd_sh_q     <= '0;
            rd_par_q    <= 1'b0;
            sdout_q     <= 1'b0;
            wr_toggle_q <= 1'b0;
            wr_addr_q   <= '0;
            status_q    <= ST_NONE;
            err_cnt_q   <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rw_q        <= rw_d;
            par_q       <= par_d;
            addr_sh_q   <= addr_sh_d;
            data_sh_q   <= data_sh_d;
            rd_sh_q     <= rd_sh_d;
            rd_par_q    <= rd_par_d;
            sdout_q     <= sdout_d;
            wr_toggle_q <= wr_toggle_d;
            wr_addr_q   <= wr_addr_d;
            status_q    <= status_d;
            err_cnt_q   <= err_cnt_d;
            busy_q      <= busy_d;
        end
    end

    assign o_sdout     = sdout_q;
    assign o_cfg       = cfg;
    assign o_wr_toggle = wr_toggle_q;
    assign o_wr_addr   = wr_addr_q;
    assign o_status    = status_q;
    assign o_err_cnt   = err_cnt_q;
    assign o_busy      = busy_q;

endmodule

// File: tb/tb_serial_cfg_regbank.sv
// Scoreboard bench for serial_cfg_regbank: a behavioural model pushes expected
// outputs while frames are driven; they are popped and compared after each edge.
module tb_serial_cfg_regbank;
    import backend_pkg::*;

    localparam int ADDR_W = 3;
    localparam int DATA_W = 8;
    localparam int NREG   = 8;
    localparam logic [NREG*DATA_W-1:0] RST_IMG = 64'h0011_2233_4455_6677;

    logic                   i_sclk = 1'b0;
    logic                   i_resetbAll;
    logic                   i_sen;
    logic                   i_sdin;
    logic                   o_sdout;
    logic [NREG*DATA_W-1:0] o_cfg;
    logic                   o_wr_toggle;
    logic [ADDR_W-1:0]      o_wr_addr;
    logic [1:0]             o_status;
    logic [3:0]             o_err_cnt;
    logic                   o_busy;

    serial_cfg_regbank #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .NREG      (NREG),
        .RESET_VAL (RST_IMG),
        .WP_EN     (1'b1)
    ) dut (
        .i_sclk      (i_sclk),
        .i_resetbAll (i_resetbAll),
        .i_sen       (i_sen),
        .i_sdin      (i_sdin),
        .o_sdout     (o_sdout),
        .o_cfg       (o_cfg),
        .o_wr_toggle (o_wr_toggle),
        .o_wr_addr   (o_wr_addr),
        .o_status    (o_status),
        .o_err_cnt   (o_err_cnt),
        .o_busy      (o_busy)
    );

    always #5 i_sclk = ~i_sclk;

    typedef enum {F_STATUS, F_TOGGLE, F_WADDR, F_ERR, F_BUSY, F_SDOUT, F_CFG} field_e;
    typedef struct {
        string       tag;
        field_e      f;
        int          idx;
        int unsigned val;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;

    logic [DATA_W-1:0] mdl[NREG];
    logic              mdl_tog;
    int unsigned       mdl_waddr;
    int unsigned       mdl_st;
    int unsigned       mdl_err;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int unsigned observe(input field_e f, input int idx);
        case (f)
            F_STATUS: return int'(o_status);
            F_TOGGLE: return int'(o_wr_toggle);
            F_WADDR:  return int'(o_wr_addr);
            F_ERR:    return int'(o_err_cnt);
            F_BUSY:   return int'(o_busy);
            F_SDOUT:  return int'(o_sdout);
            default:  return int'(o_cfg[idx*DATA_W +: DATA_W]);
        endcase
    endfunction

    task automatic push(input string tag, input field_e f, input int idx, input int unsigned val);
        exp_t e;
        e.tag = tag; e.f = f; e.idx = idx; e.val = val;
        sb.push_back(e);
    endtask

    task automatic push_state(input string tag);
        push({tag, ".status"}, F_STATUS, 0, mdl_st);
        push({tag, ".toggle"}, F_TOGGLE, 0, int'(mdl_tog));
        push({tag, ".wr_addr"}, F_WADDR, 0, mdl_waddr);
        push({tag, ".err_cnt"}, F_ERR, 0, mdl_err);
        for (int k = 0; k < NREG; k++)
            push($sformatf("%s.cfg%0d", tag, k), F_CFG, k, int'(mdl[k]));
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, observe(e.f, e.idx), e.val);
        end
    endtask

    task automatic tick(input logic sen, input logic din);
        i_sen  = sen;
        i_sdin = din;
        @(posedge i_sclk);
        #1;
    endtask

    task automatic model_reset();
        for (int k = 0; k < NREG; k++) mdl[k] = RST_IMG[k*DATA_W +: DATA_W];
        mdl_tog = 1'b0; mdl_waddr = 0; mdl_st = 0; mdl_err = 0;
    endtask

    task automatic err_inc();
        if (mdl_err < 15) mdl_err++;
    endtask

    // abort_at: number of DATA bits sent before i_sen drops (-1 = full frame)
    task automatic send_frame(input logic rw, input int addr, input logic [DATA_W-1:0] data,
                              input logic bad_par, input int abort_at, input string tag);
        logic [FRAME_LEN-1:0] frame;
        logic [DATA_W-1:0]    rd;
        frame    = {rw, 3'(addr), data, 1'b0};
        frame[0] = (^frame[FRAME_LEN-1:1]) ^ bad_par;
        rd       = (addr < NREG) ? mdl[addr] : '0;

        tick(1'b1, frame[12]);
        push({tag, ".busy_start"}, F_BUSY, 0, 1);
        drain();
        for (int i = 0; i < ADDR_W; i++) tick(1'b1, frame[11-i]);
        if (!rw) push({tag, ".sdout7"}, F_SDOUT, 0, int'(rd[7]));
        drain();
        for (int i = 0; i < DATA_W; i++) begin
            if (abort_at == i) begin
                tick(1'b0, 1'b0);
                mdl_st = 3;
                err_inc();
                push({tag, ".abort_busy"}, F_BUSY, 0, 0);
                push({tag, ".abort_sdout"}, F_SDOUT, 0, 0);
                push_state({tag, ".abort"});
                drain();
                tick(1'b0, 1'b0);
                return;
            end
            tick(1'b1, frame[8-i]);
            if (!rw && i < DATA_W-1)
                push($sformatf("%s.sdout%0d", tag, 6-i), F_SDOUT, 0, int'(rd[6-i]));
            drain();
        end
        tick(1'b1, frame[0]);
        if (bad_par) begin
            mdl_st = 2;
            err_inc();
        end else if (addr >= NREG || (rw && mdl[NREG-1][0] && addr != NREG-1)) begin
            mdl_st = 3;
            err_inc();
        end else begin
            mdl_st = 1;
            if (rw) begin
                mdl[addr] = data;
                mdl_tog   = ~mdl_tog;
                mdl_waddr = addr;
            end
        end
        if (!rw) push({tag, ".sdout_par"}, F_SDOUT, 0, int'(^rd));
        push({tag, ".busy_par"}, F_BUSY, 0, 0);
        push_state(tag);
        drain();
        tick(1'b0, 1'b0);
        push({tag, ".sdout_idle"}, F_SDOUT, 0, 0);
        push({tag, ".busy_idle"}, F_BUSY, 0, 0);
        drain();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1);
    end

    initial begin
        i_resetbAll = 1'b0;
        i_sen       = 1'b0;
        i_sdin      = 1'b0;
        model_reset();
        #12;
        push("reset.busy", F_BUSY, 0, 0);
        push("reset.sdout", F_SDOUT, 0, 0);
        push_state("reset");
        drain();
        @(negedge i_sclk);
        i_resetbAll = 1'b1;
        tick(1'b0, 1'b0);

        send_frame(1'b1, 2, 8'hA5, 1'b0, -1, "t1_write");
        send_frame(1'b1, 2, 8'h11, 1'b1, -1, "t2_badpar");

        send_frame(1'b1, 7, 8'h01, 1'b0, -1, "t3_lock");
        send_frame(1'b1, 0, 8'h3C, 1'b0, -1, "t3_locked");
        send_frame(1'b0, 0, 8'h00, 1'b0, -1, "t3_read_locked");
        send_frame(1'b1, 7, 8'h00, 1'b0, -1, "t3_unlock");
        send_frame(1'b1, 0, 8'h3C, 1'b0, -1, "t3_retry");

        send_frame(1'b0, 2, 8'hFF, 1'b0, -1, "t4_read2");
        send_frame(1'b0, 6, 8'h00, 1'b0, -1, "t4_read6");
        send_frame(1'b0, 2, 8'h00, 1'b1, -1, "t4_read_badpar");

        send_frame(1'b1, 4, 8'hC3, 1'b0, 4, "t5_abort");
        for (int n = 0; n < 20; n++)
            send_frame(1'b1, n % NREG, 8'(n), 1'b1, -1, $sformatf("t5_bad%0d", n));
        send_frame(1'b1, 1, 8'h7E, 1'b0, -1, "t5_after_sat");

        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b0);
        #2;
        i_resetbAll = 1'b0;
        #1;
        model_reset();
        push("t6_rst.busy", F_BUSY, 0, 0);
        push("t6_rst.sdout", F_SDOUT, 0, 0);
        push_state("t6_rst");
        drain();
        i_sen = 1'b0;
        #2;
        i_resetbAll = 1'b1;
        tick(1'b0, 1'b0);
        send_frame(1'b1, 5, 8'h5A, 1'b0, -1, "t6_after");
        send_frame(1'b0, 5, 8'h00, 1'b0, -1, "t6_readback");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
